// File: rtl/cart_cpu_bus.sv
// cart_cpu_bus: CPU-side cartridge bus bridge.
// Converts the core's 16-bit address/rw/data bus into the cart slot interface,
// generates the CPU cycle strobe and M2 phase, decodes cart space, captures
// mapper read data at the end of each CPU cycle and models the open-bus latch.
module cart_cpu_bus #(
   parameter int unsigned CLKS_PER_CYCLE = 3,
   parameter logic [7:0]  OB_RESET       = 8'h00
) (
   input  logic        clk_cpu,
   input  logic        rst,
   output logic        cpu_ce,
   input  logic [15:0] core_addr,
   input  logic        core_rw,
   input  logic [7:0]  core_wdata,
   input  logic [7:0]  int_rdata,
   output logic [7:0]  core_rdata,
   output logic        cart_hit,
   output logic [14:0] cart_addr,
   output logic        romsel,
   output logic        m2,
   output logic        cart_rw,
   output logic [7:0]  cart_wdata,
   input  logic [7:0]  cart_rdata
);

   localparam int unsigned   PH_W    = (CLKS_PER_CYCLE > 1) ? $clog2(CLKS_PER_CYCLE) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_CYCLE - 1);
   localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLKS_PER_CYCLE / 2);
   localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

   logic [PH_W-1:0] ph_r;
   logic [7:0]      core_rdata_r;
   logic [7:0]      ob_r;

   logic            is_int_s;
   logic            is_exp_s;
   logic            is_wram_s;
   logic            is_rom_s;
   logic            last_ph_s;
   logic [7:0]      read_val_s;

   // Region decode of the held core address.
   always_comb begin
      is_rom_s  = core_addr[15];
      is_wram_s = (core_addr[15:13] == 3'b011);
      is_int_s  = (core_addr < 16'h4020);
      is_exp_s  = ~is_int_s & ~is_wram_s & ~is_rom_s;
   end

   // Slot-side signals; reset forces the bus idle so an aborted write never reaches the mapper.
   always_comb begin
      last_ph_s  = (ph_r == PH_LAST);
      cart_addr  = core_addr[14:0];
      cart_wdata = core_wdata;
      if (rst) begin
         cpu_ce   = 1'b0;
         m2       = 1'b0;
         cart_hit = 1'b0;
         romsel   = 1'b0;
         cart_rw  = 1'b1;
      end else begin
         cpu_ce   = last_ph_s;
         m2       = (ph_r >= PH_HALF);
         cart_hit = ~is_int_s;
         romsel   = is_rom_s;
         cart_rw  = core_rw | is_int_s;
      end
   end

   // Read data source: mapper for ROM/WRAM, open bus for EXP, internal devices otherwise.
   always_comb begin
      if (is_rom_s | is_wram_s) begin
         read_val_s = cart_rdata;
      end else if (is_exp_s) begin
         read_val_s = ob_r;
      end else begin
         read_val_s = int_rdata;
      end
   end

   // Phase counter: one full CPU cycle is CLKS_PER_CYCLE clocks, restarting at 0 on reset.
   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         ph_r <= '0;
      end else if (last_ph_s) begin
         ph_r <= '0;
      end else begin
         ph_r <= ph_r + PH_ONE;
      end
   end

   // End-of-cycle capture of read data and open-bus latch update.
   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         core_rdata_r <= 8'h00;
         ob_r         <= OB_RESET;
      end else if (last_ph_s) begin
         if (core_rw) begin
            core_rdata_r <= read_val_s;
            ob_r         <= read_val_s;
         end else begin
            core_rdata_r <= core_rdata_r;
            ob_r         <= core_wdata;
         end
      end else begin
         core_rdata_r <= core_rdata_r;
         ob_r         <= ob_r;
      end
   end

   assign core_rdata = core_rdata_r;

endmodule

// File: tb/tb_cart_cpu_bus.sv
// Testbench for cart_cpu_bus: directed scenarios plus randomized CPU cycles,
// expected read data queued at issue time and compared by an independent monitor.
module tb_cart_cpu_bus;
   localparam int N = 3;

   logic        clk_cpu = 1'b0;
   logic        rst;
   logic        cpu_ce;
   logic [15:0] core_addr;
   logic        core_rw;
   logic [7:0]  core_wdata;
   logic [7:0]  int_rdata;
   logic [7:0]  core_rdata;
   logic        cart_hit;
   logic [14:0] cart_addr;
   logic        romsel;
   logic        m2;
   logic        cart_rw;
   logic [7:0]  cart_wdata;
   logic [7:0]  cart_rdata = 8'h00;

   int checks = 0;
   int errors = 0;
   int rw_low_run = 0;

   typedef struct {
      logic        is_read;
      logic [7:0]  data;
      logic [15:0] addr;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] m_ob;

   always #5 clk_cpu = ~clk_cpu;

   cart_cpu_bus #(.CLKS_PER_CYCLE(N), .OB_RESET(8'h00)) dut (
      .clk_cpu    (clk_cpu),
      .rst        (rst),
      .cpu_ce     (cpu_ce),
      .core_addr  (core_addr),
      .core_rw    (core_rw),
      .core_wdata (core_wdata),
      .int_rdata  (int_rdata),
      .core_rdata (core_rdata),
      .cart_hit   (cart_hit),
      .cart_addr  (cart_addr),
      .romsel     (romsel),
      .m2         (m2),
      .cart_rw    (cart_rw),
      .cart_wdata (cart_wdata),
      .cart_rdata (cart_rdata)
   );

   // Mapper contents: fixed byte at $C123, a simple address hash elsewhere.
   function automatic logic [7:0] map_fn(input logic [14:0] a);
      if (a == 15'h4123) return 8'hA5;
      return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
   endfunction

   // Mapper model: data valid one clock after the address is presented.
   always @(posedge clk_cpu) cart_rdata <= map_fn(cart_addr);

   // Length of the current run of low cart_rw samples.
   always @(negedge clk_cpu) rw_low_run <= cart_rw ? 0 : rw_low_run + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // 0 = INT, 1 = EXP, 2 = WRAM, 3 = ROM
   function automatic int region(input logic [15:0] a);
      if (a < 16'h4020) return 0;
      if (a < 16'h6000) return 1;
      if (a < 16'h8000) return 2;
      return 3;
   endfunction

   // Issue one CPU cycle starting at phase 0; returns just after its cpu_ce edge.
   task automatic do_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd, input logic [7:0] id);
      exp_t       e;
      int         r;
      int         phases;
      bit         done;
      logic [2:0] m2_seq;
      logic [2:0] ce_seq;
      core_addr  = a;
      core_rw    = rw;
      core_wdata = wd;
      int_rdata  = id;
      r = region(a);
      e.addr    = a;
      e.is_read = rw;
      if (rw) begin
         if (r >= 2)      e.data = map_fn(a[14:0]);
         else if (r == 1) e.data = m_ob;
         else             e.data = id;
         m_ob = e.data;
      end else begin
         e.data = 8'h00;
         m_ob   = wd;
      end
      sb_q.push_back(e);
      phases = 0;
      done   = 1'b0;
      m2_seq = 3'b000;
      ce_seq = 3'b000;
      for (int k = 0; k < N + 3 && !done; k++) begin
         @(negedge clk_cpu);
         phases++;
         m2_seq = {m2_seq[1:0], m2};
         ce_seq = {ce_seq[1:0], cpu_ce};
         check($sformatf("cart_hit@%h", a), 32'(cart_hit), 32'(r != 0));
         check($sformatf("romsel@%h", a), 32'(romsel), 32'(r == 3));
         check($sformatf("cart_rw@%h", a), 32'(cart_rw), 32'(rw || (r == 0)));
         check($sformatf("cart_addr@%h", a), 32'(cart_addr), 32'(a & 16'h7FFF));
         check($sformatf("cart_wdata@%h", a), 32'(cart_wdata), 32'(wd));
         if (cpu_ce === 1'b1) done = 1'b1;
      end
      check("cycle_len", 32'(phases), 32'(N));
      check("m2_pattern", 32'(m2_seq), 32'h3);
      check("ce_pattern", 32'(ce_seq), 32'h1);
      @(posedge clk_cpu);
      #1;
   endtask

   // Monitor: after each cpu_ce edge, pop the oldest expectation and compare read data.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_cpu);
         if (cpu_ce === 1'b1) begin
            @(posedge clk_cpu);
            #1;
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               if (e.is_read) check($sformatf("core_rdata@%h", e.addr), 32'(core_rdata), 32'(e.data));
            end
         end
      end
   end

   initial begin : stim
      logic [15:0] bnd [8];
      logic [15:0] a;
      bnd = '{16'h401F, 16'h4020, 16'h5FFF, 16'h6000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};

      // Reset with a ROM write on the core bus: the slot must still look idle.
      rst        = 1'b1;
      core_addr  = 16'hC000;
      core_rw    = 1'b0;
      core_wdata = 8'hFF;
      int_rdata  = 8'h00;
      m_ob       = 8'h00;
      @(posedge clk_cpu);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_cpu);
         check("rst_cpu_ce", 32'(cpu_ce), 32'h0);
         check("rst_m2", 32'(m2), 32'h0);
         check("rst_romsel", 32'(romsel), 32'h0);
         check("rst_cart_rw", 32'(cart_rw), 32'h1);
         check("rst_cart_hit", 32'(cart_hit), 32'h0);
         check("rst_core_rdata", 32'(core_rdata), 32'h0);
      end
      @(posedge clk_cpu);
      #1;
      rst = 1'b0;

      // First cycles after release: strobe every 3rd clock, M2 0,1,1.
      do_cycle(16'h0010, 1'b1, 8'h00, 8'h11);
      do_cycle(16'h2002, 1'b1, 8'h00, 8'h22);
      do_cycle(16'h4016, 1'b1, 8'h00, 8'h33);

      // ROM read with mapper data one clock late.
      do_cycle(16'hC123, 1'b1, 8'h00, 8'h00);

      // WRAM write then EXP read returns open bus.
      do_cycle(16'h6000, 1'b0, 8'h3C, 8'h00);
      do_cycle(16'h5000, 1'b1, 8'h00, 8'h99);

      // INT write does not reach the mapper but sets open bus.
      do_cycle(16'h0000, 1'b0, 8'h77, 8'h00);
      do_cycle(16'h4020, 1'b1, 8'h00, 8'h44);
      do_cycle(16'h401F, 1'b1, 8'h00, 8'hD2);

      // RMW double write: cart_rw low for 6 consecutive clocks.
      do_cycle(16'h8000, 1'b0, 8'h80, 8'h00);
      do_cycle(16'h8000, 1'b0, 8'h00, 8'h00);
      check("rmw_low_run", 32'(rw_low_run), 32'(2 * N));

      // Randomized cycles biased towards region boundaries.
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 2) == 0) a = bnd[$urandom_range(0, 7)];
         else                           a = 16'($urandom);
         do_cycle(a, 1'($urandom), 8'($urandom), 8'($urandom));
      end

      // Known open-bus value before the aborted cycle.
      do_cycle(16'h0100, 1'b1, 8'h00, 8'h5E);

      // Reset at phase 1 of a $E000 write aborts it.
      core_addr  = 16'hE000;
      core_rw    = 1'b0;
      core_wdata = 8'hE7;
      @(negedge clk_cpu);
      check("abort_rw_ph0", 32'(cart_rw), 32'h0);
      @(posedge clk_cpu);
      #1;
      rst = 1'b1;
      @(negedge clk_cpu);
      check("abort_rw_rst", 32'(cart_rw), 32'h1);
      check("abort_ce", 32'(cpu_ce), 32'h0);
      @(posedge clk_cpu);
      @(negedge clk_cpu);
      check("abort_rw_held", 32'(cart_rw), 32'h1);
      check("abort_rdata", 32'(core_rdata), 32'h0);
      m_ob = 8'h00;
      @(posedge clk_cpu);
      #1;
      rst = 1'b0;
      do_cycle(16'h4020, 1'b1, 8'h00, 8'h66);
      do_cycle(16'hA000, 1'b1, 8'h00, 8'h00);
      do_cycle(16'h4FFF, 1'b1, 8'h00, 8'h00);

      @(negedge clk_cpu);
      check("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
